// File: rtl/arb_muxn_pkg.sv
// Shared definitions for the arb_muxn arbitrated multiplexer.
// Holds the arbitration mode codes, the FSM encoding and the round-robin wrap helper.
package arb_muxn_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Modulo-n step for a pointer already below n; k never exceeds n, so one subtraction suffices.
  function automatic int wrap_next(input int p, input int k, input int n);
    int c;
    c = p + k;
    if (c >= n) c = c - n;
    return c;
  endfunction

endpackage

// File: rtl/arb_muxn_rr_arbiter.sv
// Combinational request arbiter: fixed priority (lowest index) or round-robin after rr_ptr.
// Produces a one-hot grant, its index, and a flag that some request is present.
module rr_arbiter
  import arb_muxn_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int MODE     = 1
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    rr_ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                any_grant
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = |req;
    // Scan from lowest to highest priority so the last hit is the winner.
    if (MODE == MODE_FIXED) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (req[i]) grant_idx = SEL_W'(i);
      end
    end else begin
      for (int k = CHANNELS; k >= 1; k--) begin
        if (req[wrap_next(int'(rr_ptr), k, CHANNELS)])
          grant_idx = SEL_W'(wrap_next(int'(rr_ptr), k, CHANNELS));
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      grant[i] = any_grant && (grant_idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/arb_muxn.sv
// N-channel arbitrated mux with a single registered output stage and packet lock.
// One-cycle latency; when the held beat is not taken, every in_ready stays low.
module arb_muxn
  import arb_muxn_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int MODE     = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     rr_ptr, lock_ch, arb_idx, win_idx;
  logic [CHANNELS-1:0]  arb_grant, grant;
  logic                 arb_any, load, xfer, win_last, win_valid;
  logic [WIDTH-1:0]     win_data;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W),
    .MODE     (MODE)
  ) u_arb (
    .req       (in_valid),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  assign load = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (xfer && !win_last) state_nxt = ST_LOCKED;
      ST_LOCKED: if (xfer && win_last)  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // While locked the grant is pinned to lock_ch even if that channel is not valid.
  always_comb begin
    grant   = arb_grant;
    win_idx = arb_idx;
    if (state == ST_LOCKED) begin
      win_idx = lock_ch;
      for (int i = 0; i < CHANNELS; i++) grant[i] = (lock_ch == SEL_W'(i));
    end
  end

  always_comb begin
    win_data  = '0;
    win_last  = 1'b0;
    win_valid = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (win_idx == SEL_W'(i)) begin
        win_data  = in_data[i*WIDTH +: WIDTH];
        win_last  = in_last[i];
        win_valid = in_valid[i];
      end
    end
  end

  assign xfer = load & ((state == ST_LOCKED) ? win_valid : arb_any);
  // Gated by rst_n so nothing is offered upstream while the block is held in reset.
  assign in_ready = (load & rst_n) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
      rr_ptr    <= SEL_W'(CHANNELS - 1);
      lock_ch   <= '0;
    end else begin
      if (load) out_valid <= xfer;
      if (xfer) begin
        out_data <= win_data;
        out_last <= win_last;
        out_sel  <= win_idx;
        if (state == ST_IDLE && !win_last) lock_ch <= win_idx;
        if (MODE == MODE_RR && win_last)   rr_ptr  <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_arb_muxn.sv
// Directed bench for arb_muxn: round-robin x4, fixed priority x4 and round-robin x3 instances.
module tb_arb_muxn;

  logic clk, rst_n;

  logic [127:0] a_d;  logic [3:0] a_v, a_l, a_rdy;
  logic [31:0]  a_od; logic a_ov, a_ol, a_ordy; logic [1:0] a_os;

  logic [127:0] b_d;  logic [3:0] b_v, b_l, b_rdy;
  logic [31:0]  b_od; logic b_ov, b_ol, b_ordy; logic [1:0] b_os;

  logic [95:0]  c_d;  logic [2:0] c_v, c_l, c_rdy;
  logic [31:0]  c_od; logic c_ov, c_ol, c_ordy; logic [1:0] c_os;

  int checks = 0;
  int failures = 0;
  bit track = 0;
  logic [31:0] rx[$];

  arb_muxn #(.WIDTH(32), .CHANNELS(4), .SEL_W(2), .MODE(1)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .in_data(a_d), .in_valid(a_v), .in_last(a_l),
    .in_ready(a_rdy), .out_data(a_od), .out_valid(a_ov), .out_last(a_ol),
    .out_sel(a_os), .out_ready(a_ordy));

  arb_muxn #(.WIDTH(32), .CHANNELS(4), .SEL_W(2), .MODE(0)) u_fp4 (
    .clk(clk), .rst_n(rst_n), .in_data(b_d), .in_valid(b_v), .in_last(b_l),
    .in_ready(b_rdy), .out_data(b_od), .out_valid(b_ov), .out_last(b_ol),
    .out_sel(b_os), .out_ready(b_ordy));

  arb_muxn #(.WIDTH(32), .CHANNELS(3), .SEL_W(2), .MODE(1)) u_rr3 (
    .clk(clk), .rst_n(rst_n), .in_data(c_d), .in_valid(c_v), .in_last(c_l),
    .in_ready(c_rdy), .out_data(c_od), .out_valid(c_ov), .out_last(c_ol),
    .out_sel(c_os), .out_ready(c_ordy));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    if (track && a_ov && a_ordy) rx.push_back(a_od);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a_d = '0; a_v = '0; a_l = '0; a_ordy = 1'b1;
    b_d = '0; b_v = '0; b_l = '0; b_ordy = 1'b1;
    c_d = '0; c_v = '0; c_l = '0; c_ordy = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_a_ov", a_ov, 0);  chk("rst_a_od", a_od, 0);
    chk("rst_a_os", a_os, 0);  chk("rst_a_ol", a_ol, 0);
    chk("rst_b_ov", b_ov, 0);  chk("rst_c_ov", c_ov, 0);
    rst_n = 1'b1;

    // One beat in flight, then asynchronous reset away from any edge
    for (int i = 0; i < 4; i++) a_d[i*32 +: 32] = 32'hA000_0000 + i;
    a_v = 4'b0010; a_l = 4'b1111;
    #1;
    chk("pre_rdy", a_rdy, 4'b0010);
    tick();
    chk("pre_ov", a_ov, 1); chk("pre_os", a_os, 1); chk("pre_od", a_od, 32'hA000_0001);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ov", a_ov, 0);  chk("arst_od", a_od, 0);
    chk("arst_ol", a_ol, 0);  chk("arst_os", a_os, 0);
    chk("arst_rdy", a_rdy, 0);
    tick();
    rst_n = 1'b1;
    a_v = 4'b0000;
    tick();

    // Round-robin, all channels valid, single-beat packets
    a_v = 4'b1111;
    #1;
    chk("rr_lat_ov", a_ov, 0);
    chk("rr_first_rdy", a_rdy, 4'b0001);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_os", a_os, k % 4);
      chk("rr_od", a_od, 32'hA000_0000 + (k % 4));
      chk("rr_ov", a_ov, 1);
    end
    a_v = 4'b0000;
    tick();
    chk("rr_drain_ov", a_ov, 0);

    // Fixed priority: ch1 starves ch3 until it drops
    for (int i = 0; i < 4; i++) b_d[i*32 +: 32] = 32'hB000_0000 + i;
    b_v = 4'b1010; b_l = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fp_rdy", b_rdy, 4'b0010);
      tick();
      chk("fp_os", b_os, 1);
      chk("fp_od", b_od, 32'hB000_0001);
    end
    b_v = 4'b1000;
    #1;
    chk("fp_rdy3", b_rdy, 4'b1000);
    tick();
    chk("fp_os3", b_os, 3);
    chk("fp_od3", b_od, 32'hB000_0003);
    b_v = 4'b0000;

    // Lock: move rr_ptr to 1, then ch2 sends a 3-beat packet with ch0 also valid
    a_v = 4'b0010; a_l = 4'b1111;
    tick();
    chk("lk_pre_os", a_os, 1);
    a_v = 4'b0101; a_l = 4'b0001; a_d[64 +: 32] = 32'hC200_0000;
    #1;
    chk("lk_rdy0", a_rdy, 4'b0100);
    tick();
    chk("lk_b0_os", a_os, 2); chk("lk_b0_od", a_od, 32'hC200_0000); chk("lk_b0_ol", a_ol, 0);
    a_d[64 +: 32] = 32'hC200_0001;
    #1;
    chk("lk_rdy1", a_rdy, 4'b0100);
    tick();
    chk("lk_b1_os", a_os, 2); chk("lk_b1_od", a_od, 32'hC200_0001);
    a_v = 4'b0001;
    #1;
    chk("lk_gap_rdy", a_rdy, 4'b0100);
    tick();
    chk("lk_gap_ov", a_ov, 0);
    a_v = 4'b0101; a_l = 4'b0101; a_d[64 +: 32] = 32'hC200_0002;
    tick();
    chk("lk_b2_os", a_os, 2); chk("lk_b2_od", a_od, 32'hC200_0002); chk("lk_b2_ol", a_ol, 1);
    a_v = 4'b0001;
    #1;
    chk("lk_post_rdy", a_rdy, 4'b0001);
    tick();
    chk("lk_post_os", a_os, 0); chk("lk_post_od", a_od, 32'hA000_0000);
    a_v = 4'b0000;
    tick();

    // Backpressure with a held beat, then drain and count deliveries
    track = 1;
    a_v = 4'b1000; a_l = 4'b1000; a_d[96 +: 32] = 32'hD000_0000;
    tick();
    chk("bp_od0", a_od, 32'hD000_0000);
    a_ordy = 1'b0; a_d[96 +: 32] = 32'hD000_0001;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rdy", a_rdy, 0);
      tick();
      chk("bp_hold_od", a_od, 32'hD000_0000);
      chk("bp_hold_ov", a_ov, 1);
    end
    a_ordy = 1'b1;
    tick();
    chk("bp_od1", a_od, 32'hD000_0001);
    a_d[96 +: 32] = 32'hD000_0002;
    tick();
    chk("bp_od2", a_od, 32'hD000_0002);
    a_v = 4'b0000;
    tick();
    chk("bp_end_ov", a_ov, 0);
    tick();
    track = 0;
    chk("bp_count", rx.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < rx.size()) chk("bp_rx", rx[k], 32'hD000_0000 + k);
    end

    // Three-channel round-robin wraps 0,1,2
    for (int i = 0; i < 3; i++) c_d[i*32 +: 32] = 32'hE000_0000 + i;
    c_v = 3'b111; c_l = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr3_os", c_os, k % 3);
      chk("rr3_od", c_od, 32'hE000_0000 + (k % 3));
    end
    c_v = 3'b000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
